// File: rtl/pipeline_sequencer_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencer.
//   seq_state_t  - sequencer FSM states
//   stage_ctrl_t - one consistent set of per-stage stall/flush/redirect controls
//   prio_t       - hazard priority levels, highest first
//   prio_ctrl()  - maps a priority level to its stage controls
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      HALT    = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic flush_mem;
      logic pc_sel;
   } stage_ctrl_t;

   typedef enum logic [2:0] {
      PRIO_HALT   = 3'd0,
      PRIO_DMEM   = 3'd1,
      PRIO_MULDIV = 3'd2,
      PRIO_BRANCH = 3'd3,
      PRIO_LOAD   = 3'd4,
      PRIO_NONE   = 3'd5
   } prio_t;

   localparam stage_ctrl_t CTRL_HALT   = 8'b1111_0000;
   localparam stage_ctrl_t CTRL_DMEM   = 8'b1111_0000;
   // Mul/div holds IF..EX and feeds MEM bubbles while EX iterates.
   localparam stage_ctrl_t CTRL_MULDIV = 8'b1110_0010;
   // Taken branch squashes the two wrong-path instructions and redirects PC.
   localparam stage_ctrl_t CTRL_BRANCH = 8'b0000_1101;
   // Load-use holds IF/ID and inserts one bubble into EX.
   localparam stage_ctrl_t CTRL_LOAD   = 8'b1100_0100;
   localparam stage_ctrl_t CTRL_NONE   = 8'b0000_0000;

   function automatic stage_ctrl_t prio_ctrl(input prio_t prio);
      stage_ctrl_t ctrl;
      case (prio)
         PRIO_HALT:   ctrl = CTRL_HALT;
         PRIO_DMEM:   ctrl = CTRL_DMEM;
         PRIO_MULDIV: ctrl = CTRL_MULDIV;
         PRIO_BRANCH: ctrl = CTRL_BRANCH;
         PRIO_LOAD:   ctrl = CTRL_LOAD;
         default:     ctrl = CTRL_NONE;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/pipeline_sequencer_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset, clears the count
//   inc   in  1  count this cycle
//   cnt   out W  current count (registered)
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;

   // Count register: increments on inc until it reaches all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (inc && (cnt_r != {W{1'b1}})) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush scheduler for the 5-stage RV32 pipeline.
// Merges combinational hazards (load-use, taken branch) with multi-cycle events
// (dmem wait, iterative mul/div, halt) into one set of stage controls.
//   inputs : LoadStall_ID, BranchTaken_EX, MulDivStart_EX, DmemBusy_MEM, Halt_WB
//   outputs: Stall_IF/ID/EX/MEM, Flush_ID/EX/MEM, PCSel_IF, MulDivBusy
//            (combinational, same-cycle), StallCnt/FlushCnt (saturating counters)
// All outputs are forced to 0 while rst_n is low.
module pipeline_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             LoadStall_ID,
   input  logic             BranchTaken_EX,
   input  logic             MulDivStart_EX,
   input  logic             DmemBusy_MEM,
   input  logic             Halt_WB,
   output logic             Stall_IF,
   output logic             Stall_ID,
   output logic             Stall_EX,
   output logic             Stall_MEM,
   output logic             Flush_ID,
   output logic             Flush_EX,
   output logic             Flush_MEM,
   output logic             PCSel_IF,
   output logic             MulDivBusy,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam int MD_W = (MD_CYCLES > 2) ? $clog2(MD_CYCLES) : 1;
   // The start cycle in RUN is the first EX cycle, so MD_WAIT covers the rest.
   localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_CYCLES - 2);

   seq_state_t      state_r, state_nxt_s;
   logic [MD_W-1:0] md_cnt_r, md_cnt_nxt_s;
   logic            is_halt_s, is_md_s, is_run_s;
   prio_t           prio_s;
   stage_ctrl_t     ctrl_s;

   // State and mul/div countdown registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= RUN;
         md_cnt_r <= {MD_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         md_cnt_r <= md_cnt_nxt_s;
      end
   end

   // Next-state logic and per-cycle priority decode.
   always_comb begin
      is_halt_s    = (state_r == HALT);
      is_md_s      = (state_r == MD_WAIT);
      // Illegal encodings behave as RUN.
      is_run_s     = !is_halt_s && !is_md_s;
      state_nxt_s  = RUN;
      md_cnt_nxt_s = md_cnt_r;
      prio_s       = PRIO_NONE;

      if (is_halt_s) begin
         prio_s = PRIO_HALT;
      end else if (DmemBusy_MEM) begin
         prio_s = PRIO_DMEM;
      end else if (is_md_s || MulDivStart_EX) begin
         prio_s = PRIO_MULDIV;
      end else if (BranchTaken_EX) begin
         prio_s = PRIO_BRANCH;
      end else if (LoadStall_ID) begin
         prio_s = PRIO_LOAD;
      end else begin
         prio_s = PRIO_NONE;
      end

      if (Halt_WB) begin
         state_nxt_s = HALT;
      end else begin
         case (state_r)
            RUN: begin
               // A busy dmem holds EX, so the op is re-presented next cycle.
               if (MulDivStart_EX && !DmemBusy_MEM) begin
                  state_nxt_s  = MD_WAIT;
                  md_cnt_nxt_s = MD_INIT;
               end else begin
                  state_nxt_s = RUN;
               end
            end
            MD_WAIT: begin
               if (DmemBusy_MEM) begin
                  state_nxt_s = MD_WAIT;
               end else if (md_cnt_r == {MD_W{1'b0}}) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s  = MD_WAIT;
                  md_cnt_nxt_s = md_cnt_r - MD_W'(1);
               end
            end
            HALT: begin
               state_nxt_s = HALT;
            end
            default: begin
               state_nxt_s = RUN;
            end
         endcase
      end

      ctrl_s = prio_ctrl(prio_s);
   end

   assign Stall_IF   = rst_n & ctrl_s.stall_if;
   assign Stall_ID   = rst_n & ctrl_s.stall_id;
   assign Stall_EX   = rst_n & ctrl_s.stall_ex;
   assign Stall_MEM  = rst_n & ctrl_s.stall_mem;
   assign Flush_ID   = rst_n & ctrl_s.flush_id;
   assign Flush_EX   = rst_n & ctrl_s.flush_ex;
   assign Flush_MEM  = rst_n & ctrl_s.flush_mem;
   assign PCSel_IF   = rst_n & ctrl_s.pc_sel;
   assign MulDivBusy = rst_n & (is_md_s | (is_run_s & MulDivStart_EX));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (Stall_IF),
      .cnt   (StallCnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (PCSel_IF),
      .cnt   (FlushCnt)
   );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer (MD_CYCLES=4, CNT_W=4).
// Reference model tracks halt, mul/div occupancy and counters abstractly.
module tb_pipeline_sequencer;

   localparam int MD = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          LoadStall_ID, BranchTaken_EX, MulDivStart_EX, DmemBusy_MEM, Halt_WB;
   logic          Stall_IF, Stall_ID, Stall_EX, Stall_MEM;
   logic          Flush_ID, Flush_EX, Flush_MEM, PCSel_IF, MulDivBusy;
   logic [CW-1:0] StallCnt, FlushCnt;

   pipeline_sequencer #(.MD_CYCLES(MD), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .LoadStall_ID   (LoadStall_ID),
      .BranchTaken_EX (BranchTaken_EX),
      .MulDivStart_EX (MulDivStart_EX),
      .DmemBusy_MEM   (DmemBusy_MEM),
      .Halt_WB        (Halt_WB),
      .Stall_IF       (Stall_IF),
      .Stall_ID       (Stall_ID),
      .Stall_EX       (Stall_EX),
      .Stall_MEM      (Stall_MEM),
      .Flush_ID       (Flush_ID),
      .Flush_EX       (Flush_EX),
      .Flush_MEM      (Flush_MEM),
      .PCSel_IF       (PCSel_IF),
      .MulDivBusy     (MulDivBusy),
      .StallCnt       (StallCnt),
      .FlushCnt       (FlushCnt)
   );

   always #5 clk = ~clk;

   logic [8:0] dut_vec;
   assign dut_vec = {Stall_IF, Stall_ID, Stall_EX, Stall_MEM,
                     Flush_ID, Flush_EX, Flush_MEM, PCSel_IF, MulDivBusy};

   int checks = 0;
   int errors = 0;

   // model state
   bit m_halt;
   bit m_md;
   int m_left;
   int m_stall;
   int m_flush;

   // window statistics (observed DUT activity over a directed sequence)
   int win_stall, win_fmem, win_pcsel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] model_out();
      logic [7:0] c;
      logic       busy;
      if (m_halt)                     c = 8'b1111_0000;
      else if (DmemBusy_MEM)          c = 8'b1111_0000;
      else if (m_md || MulDivStart_EX) c = 8'b1110_0010;
      else if (BranchTaken_EX)        c = 8'b0000_1101;
      else if (LoadStall_ID)          c = 8'b1100_0100;
      else                            c = 8'b0000_0000;
      busy = !m_halt && (m_md || MulDivStart_EX);
      return {c, busy};
   endfunction

   task automatic model_reset();
      m_halt = 0; m_md = 0; m_left = 0; m_stall = 0; m_flush = 0;
   endtask

   // Advance the model by one clock using the inputs and outputs of that cycle.
   task automatic model_step(input logic [8:0] v);
      if (v[8] && m_stall < CMAX) m_stall++;
      if (v[1] && m_flush < CMAX) m_flush++;
      if (Halt_WB) begin
         m_halt = 1;
      end else if (!m_halt && !DmemBusy_MEM) begin
         if (m_md) begin
            m_left--;
            m_md = (m_left > 0);
         end else if (MulDivStart_EX) begin
            m_left = MD - 1;
            m_md = (m_left > 0);
         end
      end
   endtask

   task automatic cycle(input logic ld, input logic br, input logic md,
                        input logic dm, input logic ht);
      logic [8:0] exp_v;
      LoadStall_ID = ld; BranchTaken_EX = br; MulDivStart_EX = md;
      DmemBusy_MEM = dm; Halt_WB = ht;
      @(negedge clk);
      exp_v = model_out();
      check("ctrl", 32'(dut_vec), 32'(exp_v));
      check("stall_cnt", 32'(StallCnt), 32'(m_stall));
      check("flush_cnt", 32'(FlushCnt), 32'(m_flush));
      win_stall += int'(Stall_IF);
      win_fmem  += int'(Flush_MEM);
      win_pcsel += int'(PCSel_IF);
      @(posedge clk);
      #1;
      model_step(exp_v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Assert reset (called just after a rising edge) with the given inputs.
   task automatic do_reset(input logic [4:0] ins);
      rst_n = 1'b0;
      {LoadStall_ID, BranchTaken_EX, MulDivStart_EX, DmemBusy_MEM, Halt_WB} = ins;
      @(negedge clk);
      check("rst_ctrl", 32'(dut_vec), 32'd0);
      check("rst_stall_cnt", 32'(StallCnt), 32'd0);
      check("rst_flush_cnt", 32'(FlushCnt), 32'd0);
      {LoadStall_ID, BranchTaken_EX, MulDivStart_EX, DmemBusy_MEM, Halt_WB} = 5'b0;
      rst_n = 1'b1;
      model_reset();
      win_stall = 0; win_fmem = 0; win_pcsel = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      {LoadStall_ID, BranchTaken_EX, MulDivStart_EX, DmemBusy_MEM, Halt_WB} = 5'b11111;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // 1: reset with all inputs high, then idle in RUN
      do_reset(5'b11111);
      idle(2);

      // 2: single load-use stall
      do_reset(5'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("t2_win_stall", 32'(win_stall), 32'd1);
      check("t2_stall_cnt", 32'(StallCnt), 32'd1);

      // 3: branch beats load-use
      do_reset(5'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("t3_flush_cnt", 32'(FlushCnt), 32'd1);
      check("t3_stall_cnt", 32'(StallCnt), 32'd0);

      // 4a: mul/div pulse, no dmem wait
      do_reset(5'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      check("t4a_win_stall", 32'(win_stall), 32'(MD));
      check("t4a_win_fmem", 32'(win_fmem), 32'(MD));

      // 4b: mul/div pulse with two dmem-busy cycles inside the window
      do_reset(5'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(6);
      check("t4b_win_stall", 32'(win_stall), 32'(MD + 2));
      check("t4b_win_fmem", 32'(win_fmem), 32'(MD));

      // 5: dmem busy masks a taken branch until EX advances
      do_reset(5'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      check("t5_pcsel_masked", 32'(win_pcsel), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("t5_pcsel", 32'(win_pcsel), 32'd1);
      check("t5_stall_cnt", 32'(StallCnt), 32'd3);

      // 6: counter saturation, then halt persists until reset
      do_reset(5'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      check("t6_sat", 32'(StallCnt), 32'(CMAX));
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      win_stall = 0;
      for (int i = 0; i < 6; i++)
         cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      check("t6_halt_stall", 32'(win_stall), 32'd6);
      do_reset(5'b11111);

      // randomized traffic with occasional mid-operation resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset(5'($urandom));
         end else begin
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 99) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
